// File: rtl/ram_arbiter.sv
// Arbiter for the single-port sram64k: flash loader at boot, then the CPU,
// with a halt/drain handshake that hands single-byte accesses to diagnostics.
module ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int SETTLE = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              read_complete_i,
  input  logic [ADDR_W-1:0] flash_addr_i,
  input  logic [DATA_W-1:0] flash_din_i,
  input  logic              flash_cs_i,
  input  logic              flash_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_din_i,
  input  logic              cpu_cs_i,
  input  logic              cpu_we_i,
  input  logic              halt_req_i,
  output logic              halt_ack_o,
  input  logic              diag_req_i,
  input  logic [ADDR_W-1:0] diag_addr_i,
  input  logic [DATA_W-1:0] diag_din_i,
  input  logic              diag_we_i,
  output logic              diag_ack_o,
  output logic [DATA_W-1:0] diag_dout_o,
  output logic              rwait_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_cs_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3,
    S_ACCESS = 3'd4,
    S_RESP   = 3'd5
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e              state_q, state_d;
  logic [3:0]          idle_q, idle_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  // State, idle counter and captured diagnostics read data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_LOAD;
      idle_q  <= 4'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idle_q  <= idle_d;
      dout_q  <= dout_d;
    end
  end

  // Next state; losing read_complete overrides everything and aborts any access.
  always_comb begin
    state_d = state_q;
    idle_d  = 4'd0;
    if (!read_complete_i) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:   state_d = S_RUN;
        S_RUN: begin
          if (halt_req_i) state_d = S_DRAIN;
          else            state_d = S_RUN;
        end
        S_DRAIN: begin
          if (!halt_req_i) begin
            state_d = S_RUN;
          end else if (cpu_cs_i) begin
            state_d = S_DRAIN;
          end else if (idle_q == SETTLE_LAST) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_DRAIN;
            idle_d  = idle_q + 4'd1;
          end
        end
        S_HALTED: begin
          if (diag_req_i)       state_d = S_ACCESS;
          else if (!halt_req_i) state_d = S_RUN;
          else                  state_d = S_HALTED;
        end
        S_ACCESS: state_d = S_RESP;
        S_RESP: begin
          if (halt_req_i) state_d = S_HALTED;
          else            state_d = S_RUN;
        end
        default:  state_d = S_LOAD;
      endcase
    end
  end

  // Read data arrives from the RAM during RESP; pass it straight through so it
  // is valid alongside diag_ack, and hold it afterwards.
  always_comb begin
    if ((state_q == S_RESP) && !diag_we_i) dout_d = ram_dout_i;
    else                                   dout_d = dout_q;
  end

  // RAM port mux, decoded from the state register only.
  always_comb begin
    ram_addr_o = flash_addr_i;
    ram_din_o  = flash_din_i;
    ram_cs_o   = flash_cs_i;
    ram_we_o   = flash_we_i;
    case (state_q)
      S_LOAD: begin
        ram_addr_o = flash_addr_i;
        ram_din_o  = flash_din_i;
        ram_cs_o   = flash_cs_i;
        ram_we_o   = flash_we_i;
      end
      S_RUN, S_DRAIN: begin
        ram_addr_o = cpu_addr_i;
        ram_din_o  = cpu_din_i;
        ram_cs_o   = cpu_cs_i;
        ram_we_o   = cpu_we_i;
      end
      S_ACCESS: begin
        ram_addr_o = diag_addr_i;
        ram_din_o  = diag_din_i;
        ram_cs_o   = 1'b1;
        ram_we_o   = diag_we_i;
      end
      S_HALTED, S_RESP: begin
        ram_addr_o = diag_addr_i;
        ram_din_o  = diag_din_i;
        ram_cs_o   = 1'b0;
        ram_we_o   = 1'b0;
      end
      default: begin
        ram_addr_o = flash_addr_i;
        ram_din_o  = flash_din_i;
        ram_cs_o   = flash_cs_i;
        ram_we_o   = flash_we_i;
      end
    endcase
  end

  assign rwait_o     = (state_q == S_RUN);
  assign halt_ack_o  = (state_q == S_HALTED) || (state_q == S_ACCESS) || (state_q == S_RESP);
  assign diag_ack_o  = (state_q == S_RESP);
  assign diag_dout_o = dout_d;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: routing table, directed handshake
// sequences, and a randomized run against an ownership-level reference model.
module tb_ram_arbiter;
  localparam int SETTLE = 4;

  logic        clk, reset, read_complete;
  logic [15:0] flash_addr, cpu_addr, diag_addr, ram_addr;
  logic [7:0]  flash_din, cpu_din, diag_din, diag_dout, ram_din, ram_dout;
  logic        flash_cs, flash_we, cpu_cs, cpu_we, halt_req, halt_ack;
  logic        diag_req, diag_we, diag_ack, rwait, ram_cs, ram_we;

  int n_pass = 0;
  int n_tot  = 0;

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .SETTLE(SETTLE)) dut (
    .clk_i(clk), .reset_i(reset), .read_complete_i(read_complete),
    .flash_addr_i(flash_addr), .flash_din_i(flash_din), .flash_cs_i(flash_cs), .flash_we_i(flash_we),
    .cpu_addr_i(cpu_addr), .cpu_din_i(cpu_din), .cpu_cs_i(cpu_cs), .cpu_we_i(cpu_we),
    .halt_req_i(halt_req), .halt_ack_o(halt_ack),
    .diag_req_i(diag_req), .diag_addr_i(diag_addr), .diag_din_i(diag_din), .diag_we_i(diag_we),
    .diag_ack_o(diag_ack), .diag_dout_o(diag_dout), .rwait_o(rwait),
    .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_cs_o(ram_cs), .ram_we_o(ram_we),
    .ram_dout_i(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sram64k: synchronous write, registered read.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!halt_ack && n < 30);
  endtask

  typedef struct {
    logic rc;
    logic [15:0] fa; logic [7:0] fd; logic fc, fw;
    logic [15:0] ca; logic [7:0] cd; logic cc, cw;
    logic [15:0] ea; logic [7:0] ed; logic ec, ew, erw;
  } vec_t;
  vec_t tbl [6];

  // Reference model: who owns the RAM, plus the diagnostics phase.
  bit       m_loaded, m_drain, m_halted;
  int       m_idle, m_phase;
  bit [7:0] m_dout;
  bit [7:0] mm [16];

  task automatic step();
    logic [15:0] ea; logic [7:0] ed; logic ec, ew; logic [7:0] edout;
    #1;
    if (!m_loaded) begin
      ea = flash_addr; ed = flash_din; ec = flash_cs; ew = flash_we;
    end else if (!m_halted) begin
      ea = cpu_addr; ed = cpu_din; ec = cpu_cs; ew = cpu_we;
    end else if (m_phase == 1) begin
      ea = diag_addr; ed = diag_din; ec = 1'b1; ew = diag_we;
    end else begin
      ea = diag_addr; ed = diag_din; ec = 1'b0; ew = 1'b0;
    end
    edout = (m_phase == 2 && !diag_we) ? mm[diag_addr[3:0]] : m_dout;
    chk("r_rwait", rwait, m_loaded && !m_drain && !m_halted);
    chk("r_halt_ack", halt_ack, m_halted);
    chk("r_diag_ack", diag_ack, m_phase == 2);
    chk("r_ram_cs", ram_cs, ec);
    chk("r_ram_we", ram_we, ew);
    if (ec) begin
      chk("r_ram_addr", ram_addr, ea);
      chk("r_ram_din", ram_din, ed);
    end
    chk("r_diag_dout", diag_dout, edout);
    @(posedge clk);
    m_dout = edout;
    if (ec && ew) mm[ea[3:0]] = ed;
    if (!read_complete) begin
      m_loaded = 0; m_drain = 0; m_halted = 0; m_phase = 0; m_idle = 0;
    end else if (!m_loaded) begin
      m_loaded = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
      m_halted = halt_req;
    end else if (m_halted) begin
      if (diag_req) m_phase = 1;
      else if (!halt_req) m_halted = 0;
    end else if (m_drain) begin
      if (!halt_req) begin m_drain = 0; m_idle = 0; end
      else if (cpu_cs) m_idle = 0;
      else if (m_idle + 1 == SETTLE) begin m_drain = 0; m_halted = 1; m_idle = 0; end
      else m_idle++;
    end else if (halt_req) begin
      m_drain = 1;
    end
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; read_complete = 1'b0; halt_req = 1'b0;
    flash_addr = 16'h1234; flash_din = 8'h00; flash_cs = 1'b1; flash_we = 1'b1;
    cpu_addr = 16'h0000; cpu_din = 8'h00; cpu_cs = 1'b0; cpu_we = 1'b0;
    diag_req = 1'b0; diag_addr = 16'h0000; diag_din = 8'h00; diag_we = 1'b0;
    #2;
    chk("rst_rwait", rwait, 1'b0);
    chk("rst_halt_ack", halt_ack, 1'b0);
    chk("rst_diag_ack", diag_ack, 1'b0);
    chk("rst_diag_dout", diag_dout, 8'h00);
    chk("rst_ram_addr", ram_addr, 16'h1234);
    chk("rst_ram_we", ram_we, 1'b1);
    tick(); tick();
    reset = 1'b0;

    // Preload the diagnostics read target through the flash port.
    flash_addr = 16'hFFFC; flash_din = 8'hA5;
    tick();
    flash_cs = 1'b0; flash_we = 1'b0;

    tbl[0] = '{1'b0, 16'h0001, 8'h11, 1'b1, 1'b0, 16'hAAAA, 8'h22, 1'b1, 1'b1, 16'h0001, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'hBEEF, 8'h5A, 1'b0, 1'b1, 16'h0101, 8'h33, 1'b1, 1'b0, 16'hBEEF, 8'h5A, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 16'h1111, 8'h44, 1'b1, 1'b1, 16'h0FF0, 8'hC3, 1'b1, 1'b0, 16'h0FF0, 8'hC3, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 16'h2222, 8'h55, 1'b1, 1'b0, 16'hFFFF, 8'h00, 1'b0, 1'b1, 16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 8'hFF, 1'b1, 1'b1, 16'h0202, 8'h66, 1'b0, 1'b0, 16'h0000, 8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 16'h3333, 8'h77, 1'b0, 1'b0, 16'h8000, 8'h7E, 1'b1, 1'b1, 16'h8000, 8'h7E, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      read_complete = tbl[i].rc;
      tick();
      flash_addr = tbl[i].fa; flash_din = tbl[i].fd; flash_cs = tbl[i].fc; flash_we = tbl[i].fw;
      cpu_addr = tbl[i].ca; cpu_din = tbl[i].cd; cpu_cs = tbl[i].cc; cpu_we = tbl[i].cw;
      #1;
      chk($sformatf("tbl%0d_addr", i), ram_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_din", i), ram_din, tbl[i].ed);
      chk($sformatf("tbl%0d_cs", i), ram_cs, tbl[i].ec);
      chk($sformatf("tbl%0d_we", i), ram_we, tbl[i].ew);
      chk($sformatf("tbl%0d_rwait", i), rwait, tbl[i].erw);
    end

    // Flash load then hand-over to the CPU.
    read_complete = 1'b0; cpu_cs = 1'b0; cpu_we = 1'b0;
    flash_addr = 16'h1234; flash_din = 8'h99; flash_cs = 1'b1; flash_we = 1'b1;
    tick();
    chk("load_ram_addr", ram_addr, 16'h1234);
    chk("load_ram_we", ram_we, 1'b1);
    chk("load_rwait", rwait, 1'b0);
    read_complete = 1'b1; cpu_addr = 16'h0ABC;
    tick();
    chk("run_ram_addr", ram_addr, 16'h0ABC);
    chk("run_rwait", rwait, 1'b1);
    flash_cs = 1'b0; flash_we = 1'b0;

    // Drain with CPU activity on cycles 2 and 3.
    halt_req = 1'b1;
    tick();
    chk("drain1_rwait", rwait, 1'b0);
    chk("drain1_halt_ack", halt_ack, 1'b0);
    tick(); cpu_cs = 1'b1;
    tick();
    n = 0;
    do begin
      tick();
      cpu_cs = 1'b0;
      n++;
      if (!halt_ack) chk("drain_rwait", rwait, 1'b0);
    end while (!halt_ack && n < 30);
    chk("halt_latency", n, 5);
    chk("halted_ram_cs", ram_cs, 1'b0);
    chk("halted_ram_we", ram_we, 1'b0);

    // Diagnostics read of the preloaded byte.
    diag_req = 1'b1; diag_addr = 16'hFFFC; diag_we = 1'b0;
    tick();
    chk("rd_access_cs", ram_cs, 1'b1);
    chk("rd_access_addr", ram_addr, 16'hFFFC);
    chk("rd_access_ack", diag_ack, 1'b0);
    tick();
    chk("rd_resp_ack", diag_ack, 1'b1);
    chk("rd_resp_dout", diag_dout, 8'hA5);
    chk("rd_resp_cs", ram_cs, 1'b0);
    diag_req = 1'b0;
    tick();
    chk("rd_after_ack", diag_ack, 1'b0);
    chk("rd_hold_dout", diag_dout, 8'hA5);

    // Diagnostics write, release, CPU read-back.
    diag_req = 1'b1; diag_addr = 16'h0400; diag_din = 8'h3C; diag_we = 1'b1;
    tick();
    chk("wr_access_cs", ram_cs, 1'b1);
    chk("wr_access_we", ram_we, 1'b1);
    tick();
    chk("wr_resp_ack", diag_ack, 1'b1);
    chk("wr_resp_dout", diag_dout, 8'hA5);
    diag_req = 1'b0;
    tick();
    halt_req = 1'b0;
    tick();
    chk("rel_rwait", rwait, 1'b1);
    chk("rel_halt_ack", halt_ack, 1'b0);
    cpu_addr = 16'h0400; cpu_cs = 1'b1; cpu_we = 1'b0;
    tick();
    cpu_cs = 1'b0;
    chk("cpu_readback", ram_dout, 8'h3C);

    // Release during an access.
    halt_req = 1'b1;
    wait_halt(n);
    chk("halt2_latency", n, SETTLE + 1);
    diag_req = 1'b1; diag_addr = 16'hFFFC; diag_we = 1'b0;
    tick();
    halt_req = 1'b0; diag_req = 1'b0;
    tick();
    chk("relacc_ack", diag_ack, 1'b1);
    chk("relacc_halt_ack", halt_ack, 1'b1);
    tick();
    chk("relacc_rwait", rwait, 1'b1);
    chk("relacc_halt_ack_off", halt_ack, 1'b0);
    chk("relacc_ack_off", diag_ack, 1'b0);

    // Abort an access by dropping read_complete.
    halt_req = 1'b1;
    wait_halt(n);
    chk("halt3_seen", halt_ack, 1'b1);
    diag_req = 1'b1;
    tick();
    chk("abort_access_cs", ram_cs, 1'b1);
    read_complete = 1'b0; diag_req = 1'b0;
    flash_addr = 16'h5555; flash_cs = 1'b1; flash_we = 1'b0;
    tick();
    chk("abort_ack", diag_ack, 1'b0);
    chk("abort_halt_ack", halt_ack, 1'b0);
    chk("abort_ram_addr", ram_addr, 16'h5555);
    chk("abort_ram_cs", ram_cs, 1'b1);
    chk("abort_rwait", rwait, 1'b0);
    tick();
    chk("abort_ack_later", diag_ack, 1'b0);
    flash_cs = 1'b0;

    // Asynchronous reset in the middle of a drain.
    read_complete = 1'b1;
    tick();
    tick();
    chk("prereset_drain_rwait", rwait, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rwait", rwait, 1'b0);
    chk("mid_rst_halt_ack", halt_ack, 1'b0);
    chk("mid_rst_diag_dout", diag_dout, 8'h00);
    chk("mid_rst_ram_addr", ram_addr, 16'h5555);
    chk("mid_rst_ram_cs", ram_cs, 1'b0);

    // Randomized run against the reference model.
    halt_req = 1'b0; read_complete = 1'b0; diag_req = 1'b0;
    tick();
    reset = 1'b0;
    m_loaded = 0; m_drain = 0; m_halted = 0; m_phase = 0; m_idle = 0; m_dout = 8'h00;
    for (int i = 0; i < 16; i++) begin
      flash_addr = 16'(i); flash_din = 8'(i * 13 + 7); flash_cs = 1'b1; flash_we = 1'b1;
      step();
    end
    for (int c = 0; c < 800; c++) begin
      read_complete = ($urandom_range(0, 49) != 0);
      flash_addr = 16'($urandom_range(0, 15)); flash_din = 8'($urandom);
      flash_cs = 1'($urandom); flash_we = 1'($urandom);
      cpu_addr = 16'($urandom_range(0, 15)); cpu_din = 8'($urandom);
      cpu_cs = ($urandom_range(0, 2) == 0); cpu_we = 1'($urandom);
      if ($urandom_range(0, 7) == 0) halt_req = !halt_req;
      diag_req = 1'($urandom);
      if (m_phase == 0) begin
        diag_addr = 16'($urandom_range(0, 15)); diag_din = 8'($urandom); diag_we = 1'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
